// File: rtl/dmem_wait_ctrl.sv
// Single-port data memory with a fixed number of wait states per access.
// Stalls the pipeline while busy and flags misaligned, out-of-range or dual requests.
module dmem_wait_ctrl #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        mem_busy,
    output logic        mem_done,
    output logic        mem_err
);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state, state_next;
    logic [3:0]  count;
    logic        lat_read, lat_write, lat_both;
    logic [31:0] lat_addr, lat_wdata;
    logic        err_q;
    logic [31:0] mem [DEPTH];

    logic                 req_any;
    logic                 eff_read, eff_write, eff_both;
    logic [31:0]          eff_addr, eff_wdata;
    logic                 access, fault;
    logic [ADDR_BITS-1:0] word_idx;

    assign req_any = mem_read | mem_write;

    // With zero wait states the access happens on the accepting edge, before the latches load.
    always_comb begin
        eff_read  = lat_read;
        eff_write = lat_write;
        eff_both  = lat_both;
        eff_addr  = lat_addr;
        eff_wdata = lat_wdata;
        if (state == IDLE) begin
            eff_read  = mem_read & ~mem_write;
            eff_write = mem_write & ~mem_read;
            eff_both  = mem_read & mem_write;
            eff_addr  = address;
            eff_wdata = write_data;
        end
    end

    assign fault    = eff_both | (eff_addr[1:0] != 2'b00) | (eff_addr[31:ADDR_BITS+2] != '0);
    assign word_idx = eff_addr[ADDR_BITS+1:2];
    assign access   = (state != DONE) && (state_next == DONE);
    assign mem_err  = err_q & (state == DONE);

    always_comb begin
        state_next = state;
        mem_busy   = 1'b0;
        mem_done   = 1'b0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    mem_busy   = 1'b1;
                    state_next = (WAIT_CYCLES > 0) ? WAIT : DONE;
                end
            end
            WAIT: begin
                mem_busy = 1'b1;
                if (count <= 4'd1) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                mem_done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count     <= 4'd0;
            lat_read  <= 1'b0;
            lat_write <= 1'b0;
            lat_both  <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (state == IDLE && req_any) begin
            lat_read  <= mem_read & ~mem_write;
            lat_write <= mem_write & ~mem_read;
            lat_both  <= mem_read & mem_write;
            lat_addr  <= address;
            lat_wdata <= write_data;
            count     <= 4'(WAIT_CYCLES);
        end else if (state == WAIT && count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    // A dual request is a fault that leaves both the array and read_data alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_data <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (access) begin
            err_q <= fault;
            if (eff_write && !fault) begin
                mem[word_idx] <= eff_wdata;
            end
            if (eff_read) begin
                read_data <= fault ? '0 : mem[word_idx];
            end
        end
    end
endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Directed bench for dmem_wait_ctrl: one instance with two wait states, one with none.
module tb_dmem_wait_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        rd2, wr2, rd0, wr0;
    logic [31:0] addr2, wdata2, addr0, wdata0;
    logic [31:0] rdata2, rdata0;
    logic        busy2, done2, err2, busy0, done0, err0;
    int          tests  = 0;
    int          failed = 0;

    always #5 clk = ~clk;

    dmem_wait_ctrl #(.ADDR_BITS(8), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .mem_read(rd2), .mem_write(wr2),
        .address(addr2), .write_data(wdata2), .read_data(rdata2),
        .mem_busy(busy2), .mem_done(done2), .mem_err(err2)
    );

    dmem_wait_ctrl #(.ADDR_BITS(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .mem_read(rd0), .mem_write(wr0),
        .address(addr0), .write_data(wdata0), .read_data(rdata0),
        .mem_busy(busy0), .mem_done(done0), .mem_err(err0)
    );

    // Issues one request and reports edges from the accepting edge (counted as 1) to mem_done.
    task automatic run_access(input bit sel, input logic rd, input logic wr,
                              input logic [31:0] a, input logic [31:0] wd,
                              output int lat, output logic [31:0] rdata, output logic err,
                              output bit busy_ok, output bit done_once);
        lat = 0; busy_ok = 1'b1; done_once = 1'b1;
        @(negedge clk);
        if ((sel ? busy0 : busy2) !== 1'b0) busy_ok = 1'b0;
        if (sel) begin rd0 = rd; wr0 = wr; addr0 = a; wdata0 = wd; end
        else     begin rd2 = rd; wr2 = wr; addr2 = a; wdata2 = wd; end
        #1;
        if ((sel ? busy0 : busy2) !== 1'b1) busy_ok = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                if (sel) begin rd0 = 1'b0; wr0 = 1'b0; end
                else     begin rd2 = 1'b0; wr2 = 1'b0; end
            end
            if ((sel ? done0 : done2) === 1'b1) begin
                lat = n;
                break;
            end
            if ((sel ? busy0 : busy2) !== 1'b1) busy_ok = 1'b0;
        end
        rdata = sel ? rdata0 : rdata2;
        err   = sel ? err0 : err2;
        if ((sel ? busy0 : busy2) !== 1'b0) busy_ok = 1'b0;
        @(posedge clk); #1;
        if ((sel ? done0 : done2) !== 1'b0) done_once = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rd2 = 0; wr2 = 0; addr2 = 0; wdata2 = 0;
        rd0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if ({rdata2, busy2, done2, err2} !== 35'd0) begin failed++; $display("[TB] FAIL reset_outputs_w2: got %h/%b%b%b expected 0/000", rdata2, busy2, done2, err2); end
        tests++; if ({rdata0, busy0, done0, err0} !== 35'd0) begin failed++; $display("[TB] FAIL reset_outputs_w0: got %h/%b%b%b expected 0/000", rdata0, busy0, done0, err0); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] rd; logic e; bit b, d;
        run_access(0, 0, 1, 32'h10, 32'hDEADBEEF, lat, rd, e, b, d);
        tests++; if (lat !== 3) begin failed++; $display("[TB] FAIL wr10_latency: got %0d expected 3", lat); end
        tests++; if (e !== 1'b0) begin failed++; $display("[TB] FAIL wr10_err: got %b expected 0", e); end
        tests++; if (b !== 1'b1) begin failed++; $display("[TB] FAIL wr10_busy: got %b expected 1", b); end
        tests++; if (d !== 1'b1) begin failed++; $display("[TB] FAIL wr10_done_pulse: got %b expected 1", d); end
        tests++; if (rd !== 32'h0) begin failed++; $display("[TB] FAIL wr10_rdata_hold: got %h expected 0", rd); end
        run_access(0, 1, 0, 32'h10, 32'h0, lat, rd, e, b, d);
        tests++; if (lat !== 3) begin failed++; $display("[TB] FAIL rd10_latency: got %0d expected 3", lat); end
        tests++; if (rd !== 32'hDEADBEEF) begin failed++; $display("[TB] FAIL rd10_data: got %h expected deadbeef", rd); end
        tests++; if (e !== 1'b0) begin failed++; $display("[TB] FAIL rd10_err: got %b expected 0", e); end
        tests++; if (b !== 1'b1) begin failed++; $display("[TB] FAIL rd10_busy: got %b expected 1", b); end
    endtask

    task automatic test_misaligned();
        int lat; logic [31:0] rd; logic e; bit b, d;
        run_access(0, 1, 0, 32'h13, 32'h0, lat, rd, e, b, d);
        tests++; if (e !== 1'b1) begin failed++; $display("[TB] FAIL rd13_err: got %b expected 1", e); end
        tests++; if (rd !== 32'h0) begin failed++; $display("[TB] FAIL rd13_data: got %h expected 0", rd); end
        tests++; if (lat !== 3) begin failed++; $display("[TB] FAIL rd13_latency: got %0d expected 3", lat); end
        run_access(0, 0, 1, 32'h11, 32'h12345678, lat, rd, e, b, d);
        tests++; if (e !== 1'b1) begin failed++; $display("[TB] FAIL wr11_err: got %b expected 1", e); end
        run_access(0, 1, 0, 32'h10, 32'h0, lat, rd, e, b, d);
        tests++; if (rd !== 32'hDEADBEEF) begin failed++; $display("[TB] FAIL rd10_unchanged: got %h expected deadbeef", rd); end
        tests++; if (e !== 1'b0) begin failed++; $display("[TB] FAIL rd10_err_clear: got %b expected 0", e); end
    endtask

    task automatic test_dual_request();
        int lat; logic [31:0] rd; logic e; bit b, d;
        run_access(0, 1, 1, 32'h20, 32'h1, lat, rd, e, b, d);
        tests++; if (e !== 1'b1) begin failed++; $display("[TB] FAIL dual_err: got %b expected 1", e); end
        tests++; if (lat !== 3) begin failed++; $display("[TB] FAIL dual_latency: got %0d expected 3", lat); end
        run_access(0, 1, 0, 32'h20, 32'h0, lat, rd, e, b, d);
        tests++; if (rd !== 32'h0) begin failed++; $display("[TB] FAIL rd20_data: got %h expected 0", rd); end
        tests++; if (e !== 1'b0) begin failed++; $display("[TB] FAIL rd20_err: got %b expected 0", e); end
    endtask

    task automatic test_range();
        int lat; logic [31:0] rd; logic e; bit b, d;
        run_access(0, 0, 1, 32'h400, 32'hCAFEF00D, lat, rd, e, b, d);
        tests++; if (e !== 1'b1) begin failed++; $display("[TB] FAIL wr400_err: got %b expected 1", e); end
        run_access(0, 1, 0, 32'h0, 32'h0, lat, rd, e, b, d);
        tests++; if (rd !== 32'h0) begin failed++; $display("[TB] FAIL rd0_unchanged: got %h expected 0", rd); end
        run_access(0, 0, 1, 32'h3FC, 32'hA5A5A5A5, lat, rd, e, b, d);
        tests++; if (e !== 1'b0) begin failed++; $display("[TB] FAIL wr3fc_err: got %b expected 0", e); end
        run_access(0, 1, 0, 32'h3FC, 32'h0, lat, rd, e, b, d);
        tests++; if (rd !== 32'hA5A5A5A5) begin failed++; $display("[TB] FAIL rd3fc_data: got %h expected a5a5a5a5", rd); end
    endtask

    task automatic test_reset_abort();
        int lat; logic [31:0] rd; logic e; bit b, d;
        @(negedge clk);
        wr2 = 1'b1; addr2 = 32'h30; wdata2 = 32'h55;
        @(posedge clk); #1;
        wr2 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        tests++; if ({rdata2, busy2, done2, err2} !== 35'd0) begin failed++; $display("[TB] FAIL abort_outputs: got %h/%b%b%b expected 0/000", rdata2, busy2, done2, err2); end
        @(negedge clk);
        reset = 1'b1;
        run_access(0, 1, 0, 32'h30, 32'h0, lat, rd, e, b, d);
        tests++; if (rd !== 32'h0) begin failed++; $display("[TB] FAIL rd30_after_abort: got %h expected 0", rd); end
        tests++; if (lat !== 3) begin failed++; $display("[TB] FAIL rd30_latency: got %0d expected 3", lat); end
        run_access(0, 1, 0, 32'h3FC, 32'h0, lat, rd, e, b, d);
        tests++; if (rd !== 32'h0) begin failed++; $display("[TB] FAIL rd3fc_cleared: got %h expected 0", rd); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd; logic e; bit b, d;
        run_access(1, 0, 1, 32'h0, 32'h11111111, lat, rd, e, b, d);
        tests++; if (lat !== 1) begin failed++; $display("[TB] FAIL w0_wr0_latency: got %0d expected 1", lat); end
        tests++; if (b !== 1'b1) begin failed++; $display("[TB] FAIL w0_wr0_busy: got %b expected 1", b); end
        run_access(1, 0, 1, 32'h4, 32'h22222222, lat, rd, e, b, d);
        tests++; if (d !== 1'b1) begin failed++; $display("[TB] FAIL w0_wr4_done_pulse: got %b expected 1", d); end
        @(negedge clk);
        rd0 = 1'b1; addr0 = 32'h0;
        @(posedge clk); #1;
        tests++; if ({done0, busy0, rdata0} !== {2'b10, 32'h11111111}) begin failed++; $display("[TB] FAIL b2b_first: got %b%b/%h expected 10/11111111", done0, busy0, rdata0); end
        addr0 = 32'h4;
        @(posedge clk); #1;
        tests++; if ({done0, busy0} !== 2'b01) begin failed++; $display("[TB] FAIL b2b_gap: got %b%b expected 01", done0, busy0); end
        @(posedge clk); #1;
        tests++; if ({done0, busy0, rdata0} !== {2'b10, 32'h22222222}) begin failed++; $display("[TB] FAIL b2b_second: got %b%b/%h expected 10/22222222", done0, busy0, rdata0); end
        rd0 = 1'b0;
        @(posedge clk); #1;
        tests++; if ({done0, busy0} !== 2'b00) begin failed++; $display("[TB] FAIL b2b_idle: got %b%b expected 00", done0, busy0); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_misaligned();
        test_dual_request();
        test_range();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
